// File: rtl/fan_ctrl_pkg.sv
// Shared types and constants for the fan-control sequencer: FSM encoding and
// config-port address map.
package fan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    REQ   = 2'd2,
    STRB  = 2'd3
  } fsm_state_e;

  localparam logic [2:0] CFG_A0      = 3'd0;
  localparam logic [2:0] CFG_A1      = 3'd1;
  localparam logic [2:0] CFG_B0      = 3'd2;
  localparam logic [2:0] CFG_B1      = 3'd3;
  localparam logic [2:0] CFG_B2      = 3'd4;
  localparam logic [2:0] CFG_SET     = 3'd5;
  localparam logic [2:0] CFG_COMMIT  = 3'd6;
  localparam logic [2:0] CFG_CLR_OVR = 3'd7;

  localparam int NUM_COEF = 5;

  function automatic logic is_coef_addr(input logic [2:0] addr);
    return (addr <= CFG_B2);
  endfunction

endpackage

// File: rtl/fan_ctrl_tick_gen.sv
// Free-running PWM prescaler and sample divider; produces the one-cycle PWM
// clock-enable and the sample tick (the enable that wraps the sample counter).
module fan_ctrl_tick_gen #(
  parameter int PWM_PRESCALE = 16,
  parameter int SAMPLE_DIV   = 256
) (
  input  logic clk_i,
  input  logic rstn_i,
  output logic clk_en_o,
  output logic sample_tick_o
);

  localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] samp_q, samp_d;
  logic          presc_wrap_s, samp_wrap_s;

  assign presc_wrap_s  = (presc_q == PW'(PWM_PRESCALE - 1));
  assign samp_wrap_s   = (samp_q == SW'(SAMPLE_DIV - 1));
  assign clk_en_o      = presc_wrap_s;
  assign sample_tick_o = presc_wrap_s & samp_wrap_s;

  // counter next-state: prescaler always runs, sample counter advances per enable
  always_comb begin
    presc_d = presc_q + PW'(1);
    samp_d  = samp_q;
    if (presc_wrap_s) begin
      presc_d = '0;
      if (samp_wrap_s) begin
        samp_d = '0;
      end else begin
        samp_d = samp_q + SW'(1);
      end
    end else begin
      samp_d = samp_q;
    end
  end

  // counter registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_q <= '0;
      samp_q  <= '0;
    end else begin
      presc_q <= presc_d;
      samp_q  <= samp_d;
    end
  end

endmodule

// File: rtl/fan_ctrl_sequencer.sv
// Fan-control sequencer: tick generation, ADC handshake FSM and atomic shadow->active
// commit of PID coefficients/setpoint. Optional ADC watchdog: FAN_SEQ_WATCHDOG_EN.
module fan_ctrl_sequencer
  import fan_ctrl_pkg::*;
#(
  parameter int ADC_BITWIDTH = 4,
  parameter int REG_BITWIDTH = 8,
  parameter int PWM_PRESCALE = 16,
  parameter int SAMPLE_DIV   = 256,
  parameter int WDT_CYCLES   = 1024
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [2:0]              cfg_addr_i,
  input  logic [REG_BITWIDTH-1:0] cfg_data_i,
  output logic                    adc_req_o,
  input  logic                    adc_ack_i,
  input  logic [ADC_BITWIDTH-1:0] adc_data_i,
  output logic                    clk_en_PWM_o,
  output logic                    dataValid_STRB_o,
  output logic [ADC_BITWIDTH-1:0] ADC_value_o,
  output logic [ADC_BITWIDTH-1:0] SET_value_o,
  output logic [REG_BITWIDTH-1:0] a0_o,
  output logic [REG_BITWIDTH-1:0] a1_o,
  output logic [REG_BITWIDTH-1:0] b0_o,
  output logic [REG_BITWIDTH-1:0] b1_o,
  output logic [REG_BITWIDTH-1:0] b2_o,
  output logic                    overrun_o,
  output logic                    fail_safe_o
);

  fsm_state_e state_q, state_d;
  logic sample_tick_s, xfer_s, enter_apply_s, ack_s, wdt_to_s;
  logic req_q, req_d, strb_q, strb_d, ready_q, ready_d;
  logic commit_q, commit_d, ovr_q, ovr_d;
  logic [REG_BITWIDTH-1:0] coef_sh_q [NUM_COEF];
  logic [REG_BITWIDTH-1:0] coef_sh_d [NUM_COEF];
  logic [REG_BITWIDTH-1:0] coef_q    [NUM_COEF];
  logic [REG_BITWIDTH-1:0] coef_d    [NUM_COEF];
  logic [ADC_BITWIDTH-1:0] set_sh_q, set_sh_d, set_q, set_d, adc_q, adc_d;

  fan_ctrl_tick_gen #(
    .PWM_PRESCALE (PWM_PRESCALE),
    .SAMPLE_DIV   (SAMPLE_DIV)
  ) u_tick_gen (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .clk_en_o      (clk_en_PWM_o),
    .sample_tick_o (sample_tick_s)
  );

  assign xfer_s        = cfg_valid_i & ready_q;
  assign enter_apply_s = (state_q == IDLE) & sample_tick_s;
  assign ack_s         = (state_q == REQ) & adc_ack_i;

  // FSM state and registered handshake outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      strb_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      strb_q  <= strb_d;
      ready_q <= ready_d;
    end
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sample_tick_s) state_d = APPLY;
        else               state_d = IDLE;
      end
      APPLY: state_d = REQ;
      REQ: begin
        if (adc_ack_i || wdt_to_s) state_d = STRB;
        else                       state_d = REQ;
      end
      STRB:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so they register alongside it
  always_comb begin
    req_d   = (state_d == REQ);
    strb_d  = (state_d == STRB);
    ready_d = (state_d != APPLY);
  end

  // Config writes, commit and overrun bookkeeping. The active set is loaded on the
  // edge into APPLY so it is already visible while the FSM sits in APPLY.
  always_comb begin
    coef_sh_d = coef_sh_q;
    coef_d    = coef_q;
    set_sh_d  = set_sh_q;
    set_d     = set_q;
    commit_d  = commit_q;
    ovr_d     = ovr_q;
    if (enter_apply_s && commit_q) begin
      coef_d   = coef_sh_q;
      set_d    = set_sh_q;
      commit_d = 1'b0;
    end else begin
      commit_d = commit_q;
    end
    if (xfer_s && is_coef_addr(cfg_addr_i)) begin
      coef_sh_d[cfg_addr_i] = cfg_data_i;
    end else if (xfer_s) begin
      case (cfg_addr_i)
        CFG_SET:     set_sh_d = cfg_data_i[ADC_BITWIDTH-1:0];
        CFG_COMMIT:  commit_d = 1'b1;
        CFG_CLR_OVR: ovr_d    = 1'b0;
        default:     ovr_d    = ovr_q;
      endcase
    end else begin
      ovr_d = ovr_q;
    end
    if (sample_tick_s && (state_q != IDLE)) ovr_d = 1'b1;
    else                                    ovr_d = ovr_d;
  end

  // ADC sample capture; a watchdog timeout substitutes full-scale (hot)
  always_comb begin
    adc_d = adc_q;
    if (ack_s)         adc_d = adc_data_i;
    else if (wdt_to_s) adc_d = '1;
    else               adc_d = adc_q;
  end

  // shadow, active, capture and flag registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      coef_sh_q <= '{default: '0};
      coef_q    <= '{default: '0};
      set_sh_q  <= '0;
      set_q     <= '0;
      adc_q     <= '0;
      commit_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      coef_sh_q <= coef_sh_d;
      coef_q    <= coef_d;
      set_sh_q  <= set_sh_d;
      set_q     <= set_d;
      adc_q     <= adc_d;
      commit_q  <= commit_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef FAN_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] wdt_q, wdt_d;
  logic          fs_q, fs_d;

  assign wdt_to_s = (state_q == REQ) & ~adc_ack_i & (wdt_q == WW'(WDT_CYCLES - 1));

  // watchdog counter (runs only in REQ) and fail-safe flag
  always_comb begin
    fs_d = fs_q;
    if (state_q == REQ) wdt_d = wdt_q + WW'(1);
    else                wdt_d = '0;
    if (ack_s)         fs_d = 1'b0;
    else if (wdt_to_s) fs_d = 1'b1;
    else               fs_d = fs_q;
  end

  // watchdog registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wdt_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      wdt_q <= wdt_d;
      fs_q  <= fs_d;
    end
  end

  assign fail_safe_o = fs_q;
`else
  assign wdt_to_s    = 1'b0;
  assign fail_safe_o = 1'b0;
`endif

  assign cfg_ready_o      = ready_q;
  assign adc_req_o        = req_q;
  assign dataValid_STRB_o = strb_q;
  assign ADC_value_o      = adc_q;
  assign SET_value_o      = set_q;
  assign a0_o             = coef_q[0];
  assign a1_o             = coef_q[1];
  assign b0_o             = coef_q[2];
  assign b1_o             = coef_q[3];
  assign b2_o             = coef_q[4];
  assign overrun_o        = ovr_q;

endmodule

// File: tb/tb_fan_ctrl_sequencer.sv
// Directed bench for fan_ctrl_sequencer with PWM_PRESCALE=4, SAMPLE_DIV=8, WDT_CYCLES=16.
// Define FAN_SEQ_WATCHDOG_EN to exercise the watchdog build.
module tb_fan_ctrl_sequencer;
  import fan_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rstn_i = 1'b0;
  logic       cfg_valid_i = 1'b0;
  logic       cfg_ready_o;
  logic [2:0] cfg_addr_i = 3'd0;
  logic [7:0] cfg_data_i = 8'h00;
  logic       adc_req_o;
  logic       adc_ack_i = 1'b0;
  logic [3:0] adc_data_i = 4'h0;
  logic       clk_en_PWM_o, dataValid_STRB_o, overrun_o, fail_safe_o;
  logic [3:0] ADC_value_o, SET_value_o;
  logic [7:0] a0_o, a1_o, b0_o, b1_o, b2_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fan_ctrl_sequencer #(
    .ADC_BITWIDTH (4),
    .REG_BITWIDTH (8),
    .PWM_PRESCALE (4),
    .SAMPLE_DIV   (8),
    .WDT_CYCLES   (16)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn_i),
    .cfg_valid_i      (cfg_valid_i),
    .cfg_ready_o      (cfg_ready_o),
    .cfg_addr_i       (cfg_addr_i),
    .cfg_data_i       (cfg_data_i),
    .adc_req_o        (adc_req_o),
    .adc_ack_i        (adc_ack_i),
    .adc_data_i       (adc_data_i),
    .clk_en_PWM_o     (clk_en_PWM_o),
    .dataValid_STRB_o (dataValid_STRB_o),
    .ADC_value_o      (ADC_value_o),
    .SET_value_o      (SET_value_o),
    .a0_o             (a0_o),
    .a1_o             (a1_o),
    .b0_o             (b0_o),
    .b1_o             (b1_o),
    .b2_o             (b2_o),
    .overrun_o        (overrun_o),
    .fail_safe_o      (fail_safe_o)
  );

  typedef struct {
    int         n;
    logic       ack;
    logic [3:0] data;
    logic       en;
    logic       req;
    logic       rdy;
    logic       strb;
    logic [3:0] val;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [7:0] data);
    chk("cfg_ready_before_write", cfg_ready_o, 1);
    cfg_valid_i = 1'b1;
    cfg_addr_i  = addr;
    cfg_data_i  = data;
    nxt();
    cfg_valid_i = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 64 && !adc_req_o; i++) nxt();
    chk("req_seen", adc_req_o, 1);
  endtask

  task automatic wait_apply(output logic [7:0] a0_prev);
    a0_prev = a0_o;
    for (int i = 0; i < 64 && cfg_ready_o; i++) begin
      a0_prev = a0_o;
      nxt();
    end
    chk("apply_seen", cfg_ready_o, 0);
  endtask

  task automatic ack_once(input logic [3:0] data);
    adc_ack_i  = 1'b1;
    adc_data_i = data;
    nxt();
    adc_ack_i  = 1'b0;
    chk("strobe_after_ack", dataValid_STRB_o, 1);
    chk("req_low_after_ack", adc_req_o, 0);
    chk("adc_value_after_ack", ADC_value_o, data);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    logic [7:0] a0_prev;
    int c;

    // cycle n counts negedges from reset release; enable when n%4==3, tick at n=31
    tbl[0]  = '{0,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[1]  = '{1,  1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[2]  = '{3,  1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[3]  = '{4,  1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[4]  = '{7,  1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[5]  = '{31, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[6]  = '{32, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[7]  = '{33, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0};
    tbl[8]  = '{34, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0};
    tbl[9]  = '{35, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
    tbl[10] = '{36, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA};
    tbl[11] = '{37, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA};

    // reset state
    repeat (3) nxt();
    chk("rst_en", clk_en_PWM_o, 0);
    chk("rst_req", adc_req_o, 0);
    chk("rst_ready", cfg_ready_o, 0);
    chk("rst_strb", dataValid_STRB_o, 0);
    chk("rst_adc", ADC_value_o, 0);
    chk("rst_set", SET_value_o, 0);
    chk("rst_coef", {a0_o, a1_o, b0_o, b1_o}, 0);
    chk("rst_b2", b2_o, 0);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_fs", fail_safe_o, 0);

    // tests 1 and 2: tick timing and first acked sample
    rstn_i = 1'b1;
    k = 0;
    for (int n = 0; n <= 37; n++) begin
      if (n != 0) nxt();
      if (k < 12 && tbl[k].n == n) begin
        chk($sformatf("en@%0d", n), clk_en_PWM_o, tbl[k].en);
        chk($sformatf("req@%0d", n), adc_req_o, tbl[k].req);
        chk($sformatf("rdy@%0d", n), cfg_ready_o, tbl[k].rdy);
        chk($sformatf("strb@%0d", n), dataValid_STRB_o, tbl[k].strb);
        chk($sformatf("val@%0d", n), ADC_value_o, tbl[k].val);
        adc_ack_i  = tbl[k].ack;
        adc_data_i = tbl[k].data;
        k++;
      end else begin
        adc_ack_i = 1'b0;
      end
    end
    chk("coef_zero_t1", {a0_o, a1_o, b0_o, b1_o, b2_o}, 0);

    // test 3: shadow writes invisible until COMMIT + next tick
    cfg_write(CFG_A0, 8'h12);
    cfg_write(CFG_SET, 8'hF7);
    wait_req();
    chk("a0_no_commit", a0_o, 8'h00);
    chk("set_no_commit", SET_value_o, 4'h0);
    ack_once(4'h3);
    nxt();
    cfg_write(CFG_COMMIT, 8'h00);
    wait_apply(a0_prev);
    chk("a0_before_apply", a0_prev, 8'h00);
    chk("a0_in_apply", a0_o, 8'h12);
    chk("set_in_apply", SET_value_o, 4'h7);
    chk("a1_in_apply", a1_o, 8'h00);
    nxt();
    chk("req_after_apply", adc_req_o, 1);

`ifdef FAN_SEQ_WATCHDOG_EN
    // test 5: ack never arrives -> timeout after 16 REQ cycles
    c = 0;
    while (adc_req_o && c < 40) begin
      c++;
      nxt();
    end
    chk("wdt_req_cycles", c, 16);
    chk("wdt_strobe", dataValid_STRB_o, 1);
    chk("wdt_value", ADC_value_o, 4'hF);
    chk("wdt_fail_safe", fail_safe_o, 1);
    nxt();
    wait_req();
    chk("fail_safe_held", fail_safe_o, 1);
    ack_once(4'h5);
    chk("fail_safe_cleared", fail_safe_o, 0);
`else
    // test 4: stalled ack causes overrun on the next tick; addr 7 clears it
    chk("ovr_before", overrun_o, 0);
    c = 0;
    while (!overrun_o && c < 40) begin
      c++;
      nxt();
    end
    chk("ovr_set_delay", c, 31);
    chk("ovr_set", overrun_o, 1);
    chk("req_held_over_tick", adc_req_o, 1);
    chk("fs_tied_low", fail_safe_o, 0);
    cfg_write(CFG_CLR_OVR, 8'h00);
    chk("ovr_cleared", overrun_o, 0);
    ack_once(4'h9);
`endif

    // test 6: reset while in REQ with a commit pending
    nxt();
    wait_req();
    cfg_write(CFG_A1, 8'h34);
    cfg_write(CFG_COMMIT, 8'h00);
    chk("req_before_reset", adc_req_o, 1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("req_async_drop", adc_req_o, 0);
    chk("a0_async_clear", a0_o, 8'h00);
    nxt();
    nxt();
    rstn_i = 1'b1;
    nxt();
    wait_apply(a0_prev);
    chk("a1_lost_commit_apply", a1_o, 8'h00);
    nxt();
    chk("req_after_reset", adc_req_o, 1);
    chk("a1_lost_commit_req", a1_o, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
